// File: rtl/life_cell_rule_pkg.sv
// life_pkg: shared state encoding and canonical B/S rule masks for life cells
package life_pkg;
  typedef enum logic [1:0] {
    S_INIT  = 2'b00,
    S_ALIVE = 2'b01,
    S_DEAD  = 2'b10
  } state_e;
  localparam logic [8:0] RULE_CONWAY_B   = 9'b0_0000_1000;
  localparam logic [8:0] RULE_CONWAY_S   = 9'b0_0000_1100;
  localparam logic [8:0] RULE_HIGHLIFE_B = 9'b0_0100_1000;
endpackage

// File: rtl/life_cell_rule_popcount.sv
// life_popcount: combinational count of set bits in nbr_i (nbr_i: N bits in, cnt_o: $clog2(N+1) bits out)
module life_popcount #(
  parameter int N = 8,
  parameter int W = $clog2(N + 1)
) (
  input  logic [N-1:0] nbr_i,
  output logic [W-1:0] cnt_o
);
  always_comb begin
    cnt_o = '0;
    for (int i = 0; i < N; i++) cnt_o = cnt_o + W'(nbr_i[i]);
  end
endmodule

// File: rtl/life_cell_rule.sv
// life_cell_rule: Game-of-Life cell with runtime B/S masks; ports clk, rst (async active-low), init, load, step, nbr, birth_mask, survive_mask -> alive, changed, age (age counter only when LIFE_CELL_AGE_EN is defined)
module life_cell_rule
  import life_pkg::*;
#(
  parameter int N_NBR = 8,
  parameter int AGE_W = 4,
  localparam int CNT_W = $clog2(N_NBR + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             init,
  input  logic             load,
  input  logic             step,
  input  logic [N_NBR-1:0] nbr,
  input  logic [N_NBR:0]   birth_mask,
  input  logic [N_NBR:0]   survive_mask,
  output logic             alive,
  output logic             changed,
  output logic [AGE_W-1:0] age
);
  state_e state_q;
  logic changed_q;
  logic [CNT_W-1:0] cnt;
  logic reseed;
  logic flip;
  life_popcount #(.N(N_NBR), .W(CNT_W)) u_pop (.nbr_i(nbr), .cnt_o(cnt));
  // Reload and the first edge out of S_INIT both reseed from init and ignore step.
  assign reseed = load || state_q == S_INIT;
  assign flip = state_q == S_ALIVE ? !survive_mask[cnt] : state_q == S_DEAD && birth_mask[cnt];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q   <= S_INIT;
      changed_q <= 1'b0;
    end else if (reseed) begin
      state_q   <= init ? S_ALIVE : S_DEAD;
      changed_q <= 1'b0;
    end else if (step && flip) begin
      state_q   <= state_q == S_ALIVE ? S_DEAD : S_ALIVE;
      changed_q <= 1'b1;
    end else
      changed_q <= 1'b0;
  assign alive   = state_q == S_ALIVE;
  assign changed = changed_q;
`ifdef LIFE_CELL_AGE_EN
  logic [AGE_W-1:0] age_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) age_q <= '0;
    else if (reseed) age_q <= '0;
    else if (step) age_q <= flip ? '0 : &age_q ? age_q : age_q + AGE_W'(1);
  assign age = age_q;
`else
  assign age = '0;
`endif
endmodule

// File: tb/tb_life_cell_rule.sv
// tb_life_cell_rule: directed and randomized checks of life_cell_rule (8- and 4-neighbour builds) against a rule-level model
module tb_life_cell_rule;
  import life_pkg::*;
  localparam int AW = 2;
  logic clk = 1'b0, rst = 1'b0, init = 1'b0, load = 1'b0, step = 1'b0;
  logic [7:0] nbr = '0;
  logic [8:0] bm = RULE_CONWAY_B, sm = RULE_CONWAY_S;
  logic [3:0] nbr4 = '0;
  logic [4:0] bm4 = 5'b01000, sm4 = 5'b01100;
  logic alive, changed, alive4, changed4;
  logic [AW-1:0] age, age4;
  int n_vec = 0, n_err = 0;
  bit m_init, m_alive, m_chg, m4_init, m4_alive, m4_chg;
  int m_age, m4_age;
  life_cell_rule #(.N_NBR(8), .AGE_W(AW)) dut (
    .clk(clk), .rst(rst), .init(init), .load(load), .step(step), .nbr(nbr),
    .birth_mask(bm), .survive_mask(sm), .alive(alive), .changed(changed), .age(age));
  life_cell_rule #(.N_NBR(4), .AGE_W(AW)) dut4 (
    .clk(clk), .rst(rst), .init(init), .load(load), .step(step), .nbr(nbr4),
    .birth_mask(bm4), .survive_mask(sm4), .alive(alive4), .changed(changed4), .age(age4));
  always #5 clk = ~clk;
  task automatic check(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic void model(input bit b_hit, input bit s_hit, inout bit in_init,
                                inout bit alv, inout bit chg, inout int ag);
    bit nxt;
    if (load || in_init) begin
      in_init = 1'b0;
      alv = init;
      chg = 1'b0;
      ag = 0;
    end else if (step) begin
      nxt = alv ? s_hit : b_hit;
      chg = nxt != alv;
      ag = chg ? 0 : (ag + 1 > (1 << AW) - 1 ? (1 << AW) - 1 : ag + 1);
      alv = nxt;
    end else chg = 1'b0;
  endfunction
  task automatic check_all();
    check("alive8", int'(alive), int'(m_alive));
    check("changed8", int'(changed), int'(m_chg));
    check("alive4", int'(alive4), int'(m4_alive));
    check("changed4", int'(changed4), int'(m4_chg));
`ifdef LIFE_CELL_AGE_EN
    check("age8", int'(age), m_age);
    check("age4", int'(age4), m4_age);
`else
    check("age8_tied", int'(age), 0);
`endif
  endtask
  task automatic tick();
    int k, k4;
    @(posedge clk);
    if (rst) begin
      k = $countones(nbr);
      k4 = $countones(nbr4);
      model(bm[k], sm[k], m_init, m_alive, m_chg, m_age);
      model(bm4[k4], sm4[k4], m4_init, m4_alive, m4_chg, m4_age);
    end
    @(negedge clk);
    check_all();
  endtask
  task automatic do_reset();
    rst = 1'b0;
    #1;
    m_init = 1'b1; m_alive = 1'b0; m_chg = 1'b0; m_age = 0;
    m4_init = 1'b1; m4_alive = 1'b0; m4_chg = 1'b0; m4_age = 0;
    check("rst_alive", int'(alive), 0);
    check("rst_changed", int'(changed), 0);
    check("rst_age", int'(age), 0);
    tick();
    rst = 1'b1;
  endtask
  task automatic drive(input bit ld, input bit st, input bit ini, input logic [7:0] n);
    load = ld; step = st; init = ini; nbr = n;
  endtask
  initial begin
    // reset then first-edge seeding from init
    init = 1'b1;
    do_reset();
    drive(0, 1, 1, 8'h00);
    tick();
    check("t1_alive", int'(alive), 1);
    check("t1_changed", int'(changed), 0);
    // Conway survive on 2, die on 1
    drive(0, 1, 1, 8'b0000_0011);
    tick();
    check("t2_survive", int'(alive), 1);
    drive(0, 1, 1, 8'b0000_0001);
    tick();
    check("t2_die", int'(alive), 0);
    check("t2_pulse", int'(changed), 1);
    drive(0, 0, 1, 8'b0000_0001);
    tick();
    check("t2_pulse_end", int'(changed), 0);
    // birth on 3, then hold with step low
    drive(0, 1, 1, 8'b0000_0111);
    tick();
    check("t3_born", int'(alive), 1);
    drive(0, 0, 1, 8'b0000_0111);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_hold_alive", int'(alive), 1);
      check("t3_hold_changed", int'(changed), 0);
    end
    // load beats a simultaneous surviving step
    drive(1, 1, 0, 8'b0000_0111);
    tick();
    check("t4_load_alive", int'(alive), 0);
    check("t4_load_changed", int'(changed), 0);
    // HighLife birth on 6
    bm = RULE_HIGHLIFE_B;
    drive(0, 1, 0, 8'b0011_1111);
    tick();
    check("t5_highlife_born", int'(alive), 1);
    check("t5_highlife_pulse", int'(changed), 1);
    bm = RULE_CONWAY_B;
`ifdef LIFE_CELL_AGE_EN
    drive(1, 0, 1, 8'h00);
    tick();
    check("t6_load_age", int'(age), 0);
    drive(0, 1, 1, 8'b0000_0011);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t6_age_seq", int'(age), i < 3 ? i + 1 : 3);
    end
    drive(0, 1, 1, 8'h00);
    tick();
    check("t6_flip_age", int'(age), 0);
    drive(0, 1, 1, 8'b0000_0111);
    tick();
    tick();
    check("t6_pre_rst_age", int'(age), 1);
    do_reset();
    check("t6_rst_age", int'(age), 0);
`endif
    // randomized generations on both neighbourhood sizes
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 49) == 0) do_reset();
      if ($urandom_range(0, 15) == 0) begin
        case ($urandom_range(0, 2))
          0: begin bm = RULE_CONWAY_B; sm = RULE_CONWAY_S; end
          1: begin bm = RULE_HIGHLIFE_B; sm = RULE_CONWAY_S; end
          default: begin bm = 9'($urandom); sm = 9'($urandom); end
        endcase
        bm4 = $urandom_range(0, 1) ? 5'b01000 : 5'($urandom);
        sm4 = $urandom_range(0, 1) ? 5'b01100 : 5'($urandom);
      end
      drive($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom));
      nbr4 = 4'($urandom);
      tick();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
